hex_msg_scroller: RTL and testbench

- Downstream consumer of the birthday-message FSM.
- Accepts 7-bit active-low seven-segment glyph codes over a valid/ready handshake and scrolls them right-to-left across NUM_DIGITS HEX displays, one digit per scroll tick.
- After the glyph flagged last has been shifted in, it shifts blanks until the display is empty, then pulses done.

---
 rtl/hex_msg_scroller.sv | 155 +++++++++++++++
 tb/tb_hex_msg_scroller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_msg_scroller.sv
// hex_msg_scroller: scrolls 7-seg glyphs right-to-left across NUM_DIGITS
// HEX digits, then drains with blanks and pulses done.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   en              scroll enable (freezes the tick divider when low)
//   clear           synchronous clear
//   glyph_valid/glyph/glyph_last/glyph_ready  upstream handshake
//   hex_out         digit k on [7k+6:7k], digit 0 = rightmost
//   busy            not idle
//   done            one-cycle pulse when the display has fully drained
module hex_msg_scroller #(
    parameter int          NUM_DIGITS = 6,
    parameter int          TICK_DIV   = 25000000,
    parameter logic [6:0]  BLANK_CODE = 7'b1111111
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clear,
    input  logic                    glyph_valid,
    input  logic [6:0]              glyph,
    input  logic                    glyph_last,
    output logic                    glyph_ready,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic                    busy,
    output logic                    done
);

    localparam int HW = 7 * NUM_DIGITS;
    localparam int CW = $clog2(TICK_DIV);
    localparam int DW = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] CNT_MAX   = CW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DRAIN_MAX = DW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            hold_valid;
    logic [6:0]      hold_glyph;
    logic            hold_last;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   drain_cnt;
    logic [HW-1:0]   disp;
    logic            done_q;

    logic            accept;
    logic            tick;
    logic            drain_end;
    logic [6:0]      shift_in;

    // A clear in the same cycle swallows any accept.
    assign accept    = glyph_valid && !hold_valid && !clear;
    assign tick      = en && (state != S_IDLE) && (cnt == CNT_MAX);
    assign drain_end = tick && (state == S_DRAIN) && !hold_valid
                       && (drain_cnt == DRAIN_MAX);
    assign shift_in  = hold_valid ? hold_glyph : BLANK_CODE;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Idle also leaves on a held glyph: a glyph accepted
    // on the very tick that finishes the drain must still get scrolled.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept || hold_valid)
                        state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (tick && hold_valid && hold_last)
                        state_nxt = S_DRAIN;
                end
                S_DRAIN: begin
                    if (drain_end)
                        state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs decoded straight from flops
    always_comb begin
        glyph_ready = !hold_valid;
        busy        = (state != S_IDLE);
    end

    assign hex_out = disp;
    assign done    = done_q;

    // Datapath: divider, holding register, display shifter, drain count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp       <= {NUM_DIGITS{BLANK_CODE}};
            hold_valid <= 1'b0;
            hold_glyph <= BLANK_CODE;
            hold_last  <= 1'b0;
            cnt        <= '0;
            drain_cnt  <= '0;
            done_q     <= 1'b0;
        end else if (clear) begin
            disp       <= {NUM_DIGITS{BLANK_CODE}};
            hold_valid <= 1'b0;
            cnt        <= '0;
            drain_cnt  <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= drain_end;

            if (state == S_IDLE)
                cnt <= '0;
            else if (en)
                cnt <= tick ? '0 : cnt + CW'(1);

            if (tick)
                disp <= {disp[HW-8:0], shift_in};

            if (tick && hold_valid)
                hold_valid <= 1'b0;
            if (accept) begin
                hold_valid <= 1'b1;
                hold_glyph <= glyph;
                hold_last  <= glyph_last;
            end

            // A real glyph during drain restarts the blank run.
            if (tick && state == S_RUN && hold_valid && hold_last)
                drain_cnt <= '0;
            else if (tick && state == S_DRAIN) begin
                if (hold_valid || drain_end)
                    drain_cnt <= '0;
                else
                    drain_cnt <= drain_cnt + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_hex_msg_scroller.sv
// tb_hex_msg_scroller: directed bench for hex_msg_scroller
// (NUM_DIGITS=4, TICK_DIV=4).
module tb_hex_msg_scroller;

    localparam int         ND = 4;
    localparam int         TD = 4;
    localparam logic [6:0] B  = 7'h7F;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b1;
    logic          clear = 1'b0;
    logic          glyph_valid = 1'b0;
    logic [6:0]    glyph = '0;
    logic          glyph_last = 1'b0;
    logic          glyph_ready;
    logic [7*ND-1:0] hex_out;
    logic          busy;
    logic          done;

    int n_vec = 0;
    int n_err = 0;
    int done_seen = 0;
    int base;
    logic [27:0] ex [4];

    hex_msg_scroller #(
        .NUM_DIGITS(ND),
        .TICK_DIV  (TD),
        .BLANK_CODE(B)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .clear      (clear),
        .glyph_valid(glyph_valid),
        .glyph      (glyph),
        .glyph_last (glyph_last),
        .glyph_ready(glyph_ready),
        .hex_out    (hex_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (rst_n && done)
            done_seen++;

    function automatic logic [27:0] hx(input logic [6:0] d3, d2, d1, d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic chk(input string tag, input logic [27:0] got,
                       input logic [27:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic stepn(input int n);
        for (int i = 0; i < n; i++)
            step();
    endtask

    task automatic offer(input logic [6:0] g, input logic l);
        glyph_valid = 1'b1;
        glyph       = g;
        glyph_last  = l;
    endtask

    task automatic drop();
        glyph_valid = 1'b0;
        glyph_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (!done && k < budget) begin
            step();
            k++;
        end
        chk(tag, 28'(done), 28'd1);
    endtask

    initial begin
        stepn(2);
        chk("rst_hex", hex_out, hx(B, B, B, B));
        chk("rst_rdy", 28'(glyph_ready), 28'd1);
        chk("rst_busy", 28'(busy), 28'd0);
        chk("rst_done", 28'(done), 28'd0);
        rst_n = 1'b1;
        step();

        // "HA" message
        base = done_seen;
        offer(7'h09, 1'b0);
        step();
        chk("ha_busy", 28'(busy), 28'd1);
        chk("ha_rdy0", 28'(glyph_ready), 28'd0);
        offer(7'h08, 1'b1);
        stepn(3);
        chk("ha_pre", hex_out, hx(B, B, B, B));
        step();
        chk("ha_t1", hex_out, hx(B, B, B, 7'h09));
        chk("ha_rdy1", 28'(glyph_ready), 28'd1);
        step();
        drop();
        stepn(3);
        chk("ha_t2", hex_out, hx(B, B, 7'h09, 7'h08));
        ex[0] = hx(B, 7'h09, 7'h08, B);
        ex[1] = hx(7'h09, 7'h08, B, B);
        ex[2] = hx(7'h08, B, B, B);
        ex[3] = hx(B, B, B, B);
        for (int i = 0; i < 4; i++) begin
            stepn(4);
            chk($sformatf("ha_blank%0d", i), hex_out, ex[i]);
            chk($sformatf("ha_done%0d", i), 28'(done), 28'(i == 3));
        end
        chk("ha_idle", 28'(busy), 28'd0);
        step();
        chk("ha_done_off", 28'(done), 28'd0);
        chk("ha_done_once", 28'(done_seen - base), 28'd1);

        // Backpressure with valid held high
        offer(7'h0C, 1'b0);
        step();
        offer(7'h11, 1'b1);
        for (int i = 1; i < 4; i++) begin
            step();
            chk($sformatf("bp_rdy_lo%0d", i), 28'(glyph_ready), 28'd0);
        end
        step();
        chk("bp_t1", hex_out, hx(B, B, B, 7'h0C));
        chk("bp_rdy_hi", 28'(glyph_ready), 28'd1);
        step();
        chk("bp_rdy_acc", 28'(glyph_ready), 28'd0);
        drop();
        stepn(3);
        chk("bp_t2", hex_out, hx(B, B, 7'h0C, 7'h11));
        wait_done("bp_done", 20);
        chk("bp_blank", hex_out, hx(B, B, B, B));
        step();

        // Underflow
        offer(7'h03, 1'b0);
        step();
        drop();
        stepn(4);
        chk("uf_t1", hex_out, hx(B, B, B, 7'h03));
        stepn(4);
        chk("uf_t2", hex_out, hx(B, B, 7'h03, B));
        stepn(4);
        chk("uf_t3", hex_out, hx(B, 7'h03, B, B));
        offer(7'h21, 1'b1);
        step();
        drop();
        stepn(3);
        chk("uf_t4", hex_out, hx(7'h03, B, B, 7'h21));
        chk("uf_busy", 28'(busy), 28'd1);
        wait_done("uf_done", 24);
        chk("uf_blank", hex_out, hx(B, B, B, B));
        step();

        // en gating
        offer(7'h40, 1'b1);
        step();
        drop();
        stepn(2);
        en = 1'b0;
        stepn(10);
        chk("en_frozen", hex_out, hx(B, B, B, B));
        chk("en_busy", 28'(busy), 28'd1);
        en = 1'b1;
        step();
        chk("en_pre", hex_out, hx(B, B, B, B));
        step();
        chk("en_tick", hex_out, hx(B, B, B, 7'h40));
        wait_done("en_done", 24);
        step();

        // clear during drain with a held glyph
        offer(7'h12, 1'b1);
        step();
        drop();
        stepn(4);
        chk("clr_t1", hex_out, hx(B, B, B, 7'h12));
        offer(7'h24, 1'b0);
        step();
        drop();
        chk("clr_held", 28'(glyph_ready), 28'd0);
        base = done_seen;
        clear = 1'b1;
        offer(7'h55, 1'b0);
        step();
        clear = 1'b0;
        drop();
        chk("clr_busy", 28'(busy), 28'd0);
        chk("clr_hex", hex_out, hx(B, B, B, B));
        chk("clr_rdy", 28'(glyph_ready), 28'd1);
        stepn(30);
        chk("clr_nodone", 28'(done_seen - base), 28'd0);
        chk("clr_stay", hex_out, hx(B, B, B, B));

        // clear swallows a same-cycle accept
        clear = 1'b1;
        offer(7'h33, 1'b0);
        step();
        clear = 1'b0;
        drop();
        chk("clracc_rdy", 28'(glyph_ready), 28'd1);
        chk("clracc_busy", 28'(busy), 28'd0);

        // async reset mid-run
        offer(7'h09, 1'b0);
        step();
        drop();
        stepn(5);
        chk("ar_run", hex_out, hx(B, B, B, 7'h09));
        base = done_seen;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_hex", hex_out, hx(B, B, B, B));
        chk("ar_rdy", 28'(glyph_ready), 28'd1);
        chk("ar_busy", 28'(busy), 28'd0);
        chk("ar_done", 28'(done), 28'd0);
        stepn(2);
        rst_n = 1'b1;
        stepn(3);
        chk("ar_nodone", 28'(done_seen - base), 28'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
